mc_control_fsm: RTL

- Multicycle MIPS control unit. Replaces the single-cycle decoder in front of the CPU datapath (PC, IR, register file, ALU, unified memory).
- Takes the opcode held in the instruction register and the ALU zero flag.
- Sequences one instruction over 3-5 clocks and drives every datapath mux select and write enable as Moore outputs.
- Also reports instruction completion and a retired-instruction count for bench checking.

---
 rtl/mc_control_fsm_pkg.sv | 51 +++++
 rtl/mc_control_fsm.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, states and
// the datapath mux select codes.
package mc_control_fsm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Final state of every instruction; leaving it retires the instruction.
  function automatic logic is_done_state(input state_t s);
    case (s)
      S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: is_done_state = 1'b1;
      default:                                            is_done_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: sequences each instruction over 3-5 clocks and
// drives all datapath selects/enables as Moore outputs of the state register.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic             pc_en,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             br_ne,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t     cur_state;
  state_t     nxt_state;
  logic       is_bne;
  logic [CNT_W-1:0] count;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cur_state <= S_IDLE;
    else        cur_state <= nxt_state;
  end

  // Branch flavour is captured in DECODE so BRANCH does not depend on a late opcode
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                      is_bne <= 1'b0;
    else if (cur_state == S_DECODE)  is_bne <= (opcode == OP_BNE);
    else                             is_bne <= is_bne;
  end

  // Retired-instruction counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                        count <= {CNT_W{1'b0}};
    else if (is_done_state(cur_state)) count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    else                               count <= count;
  end

  // Next-state logic
  always_comb begin
    nxt_state  = cur_state;
    illegal_op = 1'b0;
    case (cur_state)
      S_IDLE:   nxt_state = S_FETCH;
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:    nxt_state = S_MEMADR;
          OP_RTYPE:        nxt_state = S_EXEC;
          OP_BEQ, OP_BNE:  nxt_state = S_BRANCH;
          OP_J:            nxt_state = S_JUMP;
          OP_ADDI:         nxt_state = S_ADDIEX;
          default: begin
            illegal_op = 1'b1;
            nxt_state  = ILLEGAL_TRAP ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW) nxt_state = S_MEMRD;
        else                 nxt_state = S_MEMWR;
      end
      S_MEMRD:  nxt_state = S_MEMWB;
      S_EXEC:   nxt_state = S_RWB;
      S_ADDIEX: nxt_state = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: nxt_state = S_FETCH;
      S_HALT:   nxt_state = S_HALT;
      default:  nxt_state = S_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    br_ne         = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    case (cur_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_source     = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
        br_ne         = is_bne;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: reg_write = 1'b1;
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign pc_en       = pc_write | (pc_write_cond & (zero ^ br_ne));
  assign state       = cur_state;
  assign instr_done  = is_done_state(cur_state);
  assign instr_count = count;

endmodule
